// File: rtl/impact_bank_sequencer_if.sv
// rtl/impact_bank_sequencer_if.sv - command/response bundle between front end and bank sequencer
interface impact_bank_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int BANK_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [BANK_W-1:0] cmd_bank;
    logic [ADDR_W-1:0] cmd_word;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              busy;

    modport master (
        output cmd_valid, cmd_write, cmd_bank, cmd_word, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_bank, cmd_word, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/impact_bank_sequencer.sv
// rtl/impact_bank_sequencer.sv - timed precharge/access/recover sequencer for the IMPACT SRAM banks
module impact_bank_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int NBANKS  = 4,
    parameter int BANK_W  = 2,
    parameter int PRE_CYC = 2,
    parameter int ACC_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    impact_bank_sequencer_if.slave   cmd_if,
    output logic [NBANKS-1:0]        sram_pre_o,
    output logic [NBANKS-1:0]        sram_read_en_o,
    output logic [NBANKS-1:0]        sram_write_en_o,
    output logic [ADDR_W-1:0]        sram_word_o,
    output logic [31:0]              sram_wdata_o,
    input  logic [32*NBANKS-1:0]     sram_rdata_i
);
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ACCESS, S_RECOVER} state_t;

    localparam int CNT_MAX = (PRE_CYC > ACC_CYC) ? PRE_CYC : ACC_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q;
    logic [BANK_W-1:0] bank_q;
    logic [ADDR_W-1:0] word_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [NBANKS-1:0] bank_oh;
    logic              accept;
    logic              capture;

    assign accept  = cmd_if.cmd_valid && (state_q == S_IDLE);
    // Read data is taken on the final access cycle while the wordline is still up.
    assign capture = (state_q == S_ACCESS) && (cnt_q == '0) && !wr_q;
    assign bank_oh = {{(NBANKS-1){1'b0}}, 1'b1} << bank_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            bank_q  <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= cmd_if.cmd_write;
                bank_q  <= cmd_if.cmd_bank;
                word_q  <= cmd_if.cmd_word;
                wdata_q <= cmd_if.cmd_wdata;
            end
            if (capture) begin
                rdata_q <= sram_rdata_i[{bank_q, 5'd0} +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    state_d = S_PRE;
                    cnt_d   = CNT_W'(PRE_CYC - 1);
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_W'(ACC_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Enables and precharge decode from registered state only, so reset clears them at once.
    always_comb begin
        sram_pre_o       = '1;
        sram_read_en_o   = '0;
        sram_write_en_o  = '0;
        cmd_if.cmd_ready = (state_q == S_IDLE);
        cmd_if.busy      = (state_q != S_IDLE);
        cmd_if.rsp_valid = (state_q == S_RECOVER) && !wr_q;
        if (state_q == S_ACCESS) begin
            sram_pre_o = ~bank_oh;
            if (wr_q) begin
                sram_write_en_o = bank_oh;
            end else begin
                sram_read_en_o = bank_oh;
            end
        end
    end

    assign cmd_if.rsp_rdata = rdata_q;
    assign sram_word_o      = word_q;
    assign sram_wdata_o     = wdata_q;
endmodule

// File: tb/tb_impact_bank_sequencer.sv
// tb/tb_impact_bank_sequencer.sv - directed table-driven bench for impact_bank_sequencer
module tb_impact_bank_sequencer;
    localparam int ADDR_W = 10;
    localparam int NBANKS = 4;
    localparam int BANK_W = 2;
    localparam logic [127:0] FIXED = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    typedef struct {
        logic        wr;
        logic [1:0]  bank;
        logic [9:0]  word;
        logic [31:0] wdata;
        logic        fixed;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          en_cnt;
        int          en_first;
        int          wrong;
        int          other;
        int          rsp_n;
        int          rsp_cyc;
        int          ready_cyc;
        int          word_bad;
        logic [3:0]  pre_at_en;
        logic [31:0] rsp_d;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int inv_bad = 0;

    impact_bank_sequencer_if #(.ADDR_W(ADDR_W), .BANK_W(BANK_W)) ifa ();
    impact_bank_sequencer_if #(.ADDR_W(ADDR_W), .BANK_W(BANK_W)) ifb ();

    logic [NBANKS-1:0]   pre_a, rd_a, wr_a, pre_b, rd_b, wr_b;
    logic [ADDR_W-1:0]   word_a, word_b;
    logic [31:0]         wdata_a, wdata_b;
    logic [32*NBANKS-1:0] rdata_a, rdata_b;

    logic        sel, use_fixed;
    logic        cmd_valid, cmd_write;
    logic [1:0]  cmd_bank;
    logic [9:0]  cmd_word;
    logic [31:0] cmd_wdata;

    assign ifa.cmd_valid = cmd_valid & ~sel;
    assign ifb.cmd_valid = cmd_valid & sel;
    assign ifa.cmd_write = cmd_write;
    assign ifb.cmd_write = cmd_write;
    assign ifa.cmd_bank  = cmd_bank;
    assign ifb.cmd_bank  = cmd_bank;
    assign ifa.cmd_word  = cmd_word;
    assign ifb.cmd_word  = cmd_word;
    assign ifa.cmd_wdata = cmd_wdata;
    assign ifb.cmd_wdata = cmd_wdata;

    impact_bank_sequencer #(.ADDR_W(ADDR_W), .NBANKS(NBANKS), .BANK_W(BANK_W), .PRE_CYC(2), .ACC_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .cmd_if(ifa.slave),
        .sram_pre_o(pre_a), .sram_read_en_o(rd_a), .sram_write_en_o(wr_a),
        .sram_word_o(word_a), .sram_wdata_o(wdata_a), .sram_rdata_i(rdata_a)
    );

    impact_bank_sequencer #(.ADDR_W(ADDR_W), .NBANKS(NBANKS), .BANK_W(BANK_W), .PRE_CYC(1), .ACC_CYC(4)) dut_b (
        .clk(clk), .rst(rst), .cmd_if(ifb.slave),
        .sram_pre_o(pre_b), .sram_read_en_o(rd_b), .sram_write_en_o(wr_b),
        .sram_word_o(word_b), .sram_wdata_o(wdata_b), .sram_rdata_i(rdata_b)
    );

    // SRAM model behind dut_a; dut_b sees the fixed per-bank pattern.
    logic [31:0] mem [NBANKS][1024];
    initial begin
        for (int b = 0; b < NBANKS; b++)
            for (int w = 0; w < 1024; w++) mem[b][w] = 32'h0;
    end
    always @(posedge clk) begin
        for (int b = 0; b < NBANKS; b++)
            if (wr_a[b]) mem[b][word_a] <= wdata_a;
    end
    always_comb begin
        rdata_a = FIXED;
        if (!use_fixed)
            for (int b = 0; b < NBANKS; b++) rdata_a[32*b +: 32] = mem[b][word_a];
    end
    assign rdata_b = FIXED;

    logic        m_ready, m_busy, m_rsp_valid;
    logic [31:0] m_rsp_rdata;
    logic [3:0]  m_pre, m_rd, m_wr;
    logic [9:0]  m_word;
    assign m_ready     = sel ? ifb.cmd_ready : ifa.cmd_ready;
    assign m_busy      = sel ? ifb.busy      : ifa.busy;
    assign m_rsp_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
    assign m_rsp_rdata = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
    assign m_pre       = sel ? pre_b : pre_a;
    assign m_rd        = sel ? rd_b  : rd_a;
    assign m_wr        = sel ? wr_b  : wr_a;
    assign m_word      = sel ? word_b : word_a;

    function automatic bit inv_ok(input logic [3:0] p, input logic [3:0] r, input logic [3:0] w);
        return ($countones(r | w) <= 1) && ((r & w) == 4'h0) && ((p & (r | w)) == 4'h0);
    endfunction

    always @(negedge clk) begin
        if (!inv_ok(pre_a, rd_a, wr_a)) inv_bad++;
        if (!inv_ok(pre_b, rd_b, wr_b)) inv_bad++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] b, input logic [9:0] wd, input logic [31:0] d,
                         output int waits);
        cmd_write = w; cmd_bank = b; cmd_word = wd; cmd_wdata = d; cmd_valid = 1'b1;
        waits = 0;
        while (!m_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
    endtask

    task automatic observe(input logic w, input logic [1:0] b, input logic [9:0] wd, input logic hold,
                           input logic nw, input logic [1:0] nb, input logic [9:0] nwd, input logic [31:0] nd,
                           output obs_t o);
        logic [3:0] en_vec, oth_vec, oh;
        o = '{default: 0};
        oh = 4'b0001 << b;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            en_vec  = w ? m_wr : m_rd;
            oth_vec = w ? m_rd : m_wr;
            if ((en_vec & oh) != 4'h0) begin
                o.en_cnt++;
                if (o.en_first == 0) begin
                    o.en_first  = c;
                    o.pre_at_en = m_pre;
                end
            end
            o.wrong += $countones(oth_vec);
            o.other += $countones(en_vec & ~oh);
            if (m_rsp_valid) begin
                o.rsp_n++;
                o.rsp_cyc = c;
            end
            if (m_busy && m_word !== wd) o.word_bad++;
            if (c == 1) begin
                if (hold) begin
                    cmd_write = nw; cmd_bank = nb; cmd_word = nwd; cmd_wdata = nd;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (m_ready) begin
                o.ready_cyc = c;
                o.rsp_d = m_rsp_rdata;
                break;
            end
        end
    endtask

    task automatic check_obs(input string tag, input obs_t o, input logic w, input logic [1:0] b,
                             input int p, input int a, input logic [31:0] exp_rd);
        logic [3:0] oh;
        oh = 4'b0001 << b;
        chk({tag, " en_cnt"}, o.en_cnt, a);
        chk({tag, " en_first"}, o.en_first, p + 1);
        chk({tag, " wrong_en"}, o.wrong, 0);
        chk({tag, " other_bank"}, o.other, 0);
        chk({tag, " pre_in_access"}, {28'h0, o.pre_at_en}, {28'h0, ~oh});
        chk({tag, " rsp_count"}, o.rsp_n, w ? 0 : 1);
        chk({tag, " rsp_cycle"}, o.rsp_cyc, w ? 0 : p + a + 1);
        chk({tag, " ready_cycle"}, o.ready_cyc, p + a + 2);
        chk({tag, " word_stable"}, o.word_bad, 0);
        chk({tag, " rsp_rdata"}, o.rsp_d, exp_rd);
    endtask

    vec_t        vecs [8];
    obs_t        o;
    int          waits;
    logic [31:0] last_rdata;
    int          seen;

    initial begin
        vecs[0] = '{1'b1, 2'd0, 10'h3FF, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 2'd0, 10'h3FF, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 2'd1, 10'h000, 32'hA5A55A5A, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 2'd3, 10'h123, 32'h0BADF00D, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 2'd3, 10'h123, 32'h0,        1'b0, 32'h0BADF00D};
        vecs[5] = '{1'b0, 2'd1, 10'h000, 32'h0,        1'b0, 32'hA5A55A5A};
        vecs[6] = '{1'b0, 2'd2, 10'h055, 32'h0,        1'b1, 32'h33333333};
        vecs[7] = '{1'b0, 2'd0, 10'h001, 32'h0,        1'b1, 32'h11111111};

        sel = 1'b0; use_fixed = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_bank = '0; cmd_word = '0; cmd_wdata = '0;
        last_rdata = 32'h0;

        repeat (3) @(negedge clk);
        chk("reset cmd_ready", ifa.cmd_ready, 1);
        chk("reset busy", ifa.busy, 0);
        chk("reset rsp_valid", ifa.rsp_valid, 0);
        chk("reset rsp_rdata", ifa.rsp_rdata, 0);
        chk("reset sram_pre", pre_a, 4'hF);
        chk("reset read_en", rd_a, 0);
        chk("reset write_en", wr_a, 0);
        chk("reset sram_word", word_a, 0);
        chk("reset sram_wdata", wdata_a, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            use_fixed = vecs[i].fixed;
            issue(vecs[i].wr, vecs[i].bank, vecs[i].word, vecs[i].wdata, waits);
            chk($sformatf("vec%0d accept_wait", i), waits, 0);
            observe(vecs[i].wr, vecs[i].bank, vecs[i].word, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0, o);
            if (!vecs[i].wr) last_rdata = vecs[i].exp_rdata;
            check_obs($sformatf("vec%0d", i), o, vecs[i].wr, vecs[i].bank, 2, 2, last_rdata);
        end
        use_fixed = 1'b0;

        // Back-to-back: read request is held through the write's busy window.
        issue(1'b1, 2'd1, 10'h200, 32'hCAFEF00D, waits);
        observe(1'b1, 2'd1, 10'h200, 1'b1, 1'b0, 2'd3, 10'h123, 32'h0, o);
        check_obs("b2b write", o, 1'b1, 2'd1, 2, 2, last_rdata);
        issue(1'b0, 2'd3, 10'h123, 32'h0, waits);
        chk("b2b read accept_wait", waits, 0);
        observe(1'b0, 2'd3, 10'h123, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0, o);
        last_rdata = 32'h0BADF00D;
        check_obs("b2b read", o, 1'b0, 2'd3, 2, 2, last_rdata);

        // Reset asserted asynchronously during a write's ACCESS phase.
        issue(1'b1, 2'd2, 10'h010, 32'h12345678, waits);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst write_en before", wr_a, 4'b0100);
        #1 rst = 1'b1;
        #1;
        chk("midrst write_en", wr_a, 0);
        chk("midrst sram_pre", pre_a, 4'hF);
        chk("midrst busy", ifa.busy, 0);
        chk("midrst cmd_ready", ifa.cmd_ready, 1);
        chk("midrst rsp_rdata", ifa.rsp_rdata, 0);
        chk("midrst sram_word", word_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ifa.rsp_valid || wr_a != 4'h0 || !ifa.cmd_ready) seen++;
        end
        chk("midrst idle after release", seen, 0);

        // Parameter sweep instance: PRE_CYC=1, ACC_CYC=4.
        sel = 1'b1;
        @(negedge clk);
        issue(1'b1, 2'd2, 10'h0AA, 32'h77777777, waits);
        observe(1'b1, 2'd2, 10'h0AA, 1'b1, 1'b0, 2'd2, 10'h0BB, 32'h0, o);
        check_obs("sweep write", o, 1'b1, 2'd2, 1, 4, 32'h0);
        issue(1'b0, 2'd2, 10'h0BB, 32'h0, waits);
        chk("sweep read accept_wait", waits, 0);
        observe(1'b0, 2'd2, 10'h0BB, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0, o);
        check_obs("sweep read", o, 1'b0, 2'd2, 1, 4, 32'h33333333);

        chk("invariant violations", inv_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/impact_bank_sequencer.md
# impact_bank_sequencer

Command-level controller that sequences precharge, wordline access and data capture for the IMPACT SRAM banks. It sits between the GPIO/register front end and the bank word decoders and SRAM blocks. It replaces the tied-high PRE and free-running enables with a timed, mutually exclusive precharge → access → recover cycle per command. One command is in flight at a time; read data returns as a full 32-bit word for the downstream byte mux.

## Interface
- ADDR_W, 10, word address width; drives the 1024-line word decoder
- NBANKS, 4, number of SRAM banks; must equal 2**BANK_W
- BANK_W, 2, bank select width
- PRE_CYC, 2, precharge cycles per command; legal range ≥1
- ACC_CYC, 2, wordline/enable cycles per command; legal range ≥1

- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_bank  in  BANK_W  target bank
- cmd_word  in  ADDR_W  target word
- cmd_wdata  in  32  write word, already byte-assembled
- rsp_valid  out  1  one-cycle pulse; read data valid
- rsp_rdata  out  32  captured read word; holds until the next read capture
- busy  out  1  state ≠ IDLE
- sram_pre  out  NBANKS  per-bank bitline precharge, active-high
- sram_read_en  out  NBANKS  per-bank read enable
- sram_write_en  out  NBANKS  per-bank write enable
- sram_word  out  ADDR_W  latched word address to the decoders
- sram_wdata  out  32  latched write data
- sram_rdata  in  32*NBANKS  bank outputs, bank b at [32b+31:32b]

## Operation
- FSM states: IDLE, PRE, ACCESS, RECOVER.
- IDLE:
  - cmd_ready=1; all sram_pre=1; all enables=0.
  - On accept, latch cmd_write, cmd_bank, cmd_word and cmd_wdata into internal registers, load the cycle counter, and go to PRE.
- PRE:
  - Selected bank sram_pre=1; enables=0; sram_word and sram_wdata are driven from the latches.
  - Stays PRE_CYC cycles, then goes to ACCESS.
- ACCESS:
  - Selected bank sram_pre=0.
  - The selected bank's sram_write_en (write) or sram_read_en (read) is 1 for exactly ACC_CYC cycles.
  - Read: on the last ACCESS cycle, the selected bank's sram_rdata slice is registered into rsp_rdata.
- RECOVER:
  - Lasts one cycle; all enables=0; all sram_pre=1.
  - For reads, rsp_valid=1 in this cycle only. There is no backpressure on the response.
  - Then go to IDLE.
- Invariants, every cycle:
  - At most one bank has any enable high.
  - read_en and write_en are never both high.
  - No bank has sram_pre and an enable high together.
  - Unselected banks hold sram_pre=1 and enables=0.
- sram_word and sram_wdata change only on accept. Both are stable for the entire PRE/ACCESS/RECOVER window.
- cmd_valid while busy is ignored; the requester holds it until cmd_ready.
- Writes never assert rsp_valid and leave rsp_rdata unchanged.

## Timing
- Reset value of every output:
  - cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0.
  - sram_pre=all 1s, sram_read_en=0, sram_write_en=0, sram_word=0, sram_wdata=0.
  - State=IDLE.
- rst mid-command: enables drop and precharge reasserts asynchronously, with no partial response. Release is sampled at the next clk edge.
- Accept at edge T:
  - PRE covers T+1 … T+PRE_CYC.
  - ACCESS covers T+PRE_CYC+1 … T+PRE_CYC+ACC_CYC.
  - RECOVER is at T+PRE_CYC+ACC_CYC+1.
  - IDLE and cmd_ready=1 at T+PRE_CYC+ACC_CYC+2.
- Defaults: rsp_valid is in cycle T+5; the earliest next accept is T+6. Throughput is 1 command per PRE_CYC+ACC_CYC+2 cycles.
- A cmd_valid held continuously through RECOVER is accepted on the first IDLE cycle. There is no idle gap beyond that cycle.

## Test plan
- Reset state: assert rst mid-sim → all outputs at their reset values in the same cycle, independent of clk.
- Write then read: write 0xDEADBEEF to bank 0, word 0x3FF, then read it back:
  - write_en[0] is high for exactly 2 cycles, with no rsp_valid.
  - The read gives rsp_valid at T+5 with rsp_rdata=0xDEADBEEF.
- Bank isolation: read bank 2 with sram_rdata slices set to 0x11111111, 0x22222222, 0x33333333 and 0x44444444 → rsp_rdata=0x33333333; only read_en[2] ever toggles.
- Back-to-back: hold cmd_valid for a write followed by a read → accepts at T and T+6. The busy-period cmd_valid is ignored, and the latched address never changes mid-command.
- Reset mid-ACCESS: assert rst during a write's ACCESS → write_en drops immediately and sram_pre=1111. After release the FSM returns to IDLE and rsp_valid is never seen.
- Parameter sweep PRE_CYC=1, ACC_CYC=4 → enable high for exactly 4 cycles, next accept at T+7. The mutual-exclusion invariants are asserted every cycle.
